lc_isolation_sequencer: RTL and testbench
=========================================

Name: lc_isolation_sequencer

Overview:
Parametrised, sequenced isolation gate between a power-gated layer controller and the always-on domain (MBus, register file, memory, interrupt). Unlike a pure combinational clamp, it drains in-flight request/ack handshakes before clamping and offers clamp-to-zero or hold-last-value modes. On release it keeps outputs isolated for a programmable settle window. Instantiated once per isolated bundle, on the always-on clock.

Parameters:
DATA_W, 64, width of the non-handshake bundle (address/data/load/mask bits).
REQ_W, 4, number of request lines that must drain, e.g. TX_REQ, MEM_REQ, RX_ACK, TX_RESP_ACK.
HOLD_MODE, 0, 0 = isolated bundle driven to all-zero; 1 = isolated bundle holds the snapshot taken on entry to ISO.
DRAIN_TIMEOUT, 255, maximum cycles spent in DRAIN before forced isolation (at least 1).
SETTLE_CYCLES, 4, cycles outputs stay isolated after ISO_REQ drops (0 allowed).

Ports:
CLK  input  1  always-on clock
RESETn  input  1  asynchronous active-low reset
ISO_REQ  input  1  level isolation request from the power controller
BUNDLE_IN  input  DATA_W  bundle from the layer controller
REQ_IN  input  REQ_W  request lines from the layer controller
ACK_IN  input  REQ_W  per-line acknowledge from the far side
BUNDLE_OUT  output  DATA_W  gated bundle
REQ_OUT  output  REQ_W  gated request lines
ISO_ACK  output  1  high when outputs are fully isolated (states ISO and SETTLE)
DRAIN_TO  output  1  sticky: last drain ended by timeout; cleared on next entry to DRAIN

Behaviour:
- States: RUN, DRAIN, ISO, SETTLE. Reset state is ISO: snapshot = 0, pending = 0, counters = 0, DRAIN_TO = 0. All outputs are therefore 0 and ISO_ACK = 1 during reset.
- RUN: BUNDLE_OUT = BUNDLE_IN and REQ_OUT = REQ_IN, combinational with zero latency; ISO_ACK = 0.
  - ISO_REQ = 1 moves to DRAIN. At that edge: pending <= REQ_IN, drain counter <= 0, DRAIN_TO <= 0.
- DRAIN:
  - BUNDLE_OUT = BUNDLE_IN.
  - REQ_OUT = REQ_IN & pending. New requests are masked; requests already pending stay visible.
  - Each cycle, pending[i] clears if ACK_IN[i] = 1 or REQ_IN[i] = 0.
  - Go to ISO when the next value of pending is 0, or when the counter reaches DRAIN_TIMEOUT-1. The timeout exit sets DRAIN_TO = 1.
  - ISO_REQ = 0 in DRAIN aborts straight to RUN. No settle; pending is cleared.
  - Timeout and the drain condition in the same cycle: the drain condition wins and DRAIN_TO stays 0.
- ISO:
  - REQ_OUT = 0.
  - BUNDLE_OUT = 0 if HOLD_MODE = 0, otherwise the snapshot.
  - The snapshot is BUNDLE_IN registered on the DRAIN-to-ISO edge. When ISO is reached from reset, the snapshot is 0.
  - ISO_REQ = 0 moves to SETTLE with settle counter <= 0, or directly to RUN if SETTLE_CYCLES = 0.
- SETTLE:
  - Outputs are as in ISO; ISO_ACK = 1.
  - The counter increments each cycle; at SETTLE_CYCLES-1 the block moves to RUN.
  - ISO_REQ = 1 in SETTLE returns to ISO immediately, with the snapshot unchanged.
- Counter width is $clog2(max(DRAIN_TIMEOUT, SETTLE_CYCLES) + 1). Counters saturate and never wrap.
- Asynchronous reset mid-DRAIN or mid-SETTLE forces ISO immediately, the same as power-up.
- ACK_IN is ignored outside DRAIN. All state is updated on the rising edge of CLK.

Test Plan:
- Reset, then ISO_REQ = 0, SETTLE_CYCLES = 4, BUNDLE_IN = 0xA5 -> outputs 0 and ISO_ACK = 1 for 4 cycles after RESETn rises; then BUNDLE_OUT = 0xA5 and ISO_ACK = 0.
- In RUN, REQ_IN = 4'b0011; raise ISO_REQ; raise REQ_IN[2] next cycle; ACK_IN[0] at +2, ACK_IN[1] at +5 -> REQ_OUT[2] stays 0 throughout; ISO reached the cycle after ACK_IN[1]; DRAIN_TO = 0.
- DRAIN_TIMEOUT = 8, REQ_IN[0] = 1, ACK_IN never asserted -> ISO after exactly 8 DRAIN cycles; DRAIN_TO = 1; REQ_OUT = 0.
- HOLD_MODE = 1, BUNDLE_IN = 0x1234 at ISO entry, then changed to 0xFFFF -> BUNDLE_OUT stays 0x1234 through ISO and SETTLE. With HOLD_MODE = 0 the same stimulus gives 0.
- In SETTLE, cycle 2, re-raise ISO_REQ -> back to ISO next cycle with ISO_ACK held at 1; on release, the full SETTLE_CYCLES are counted again.
- Drop ISO_REQ in DRAIN cycle 1 -> RUN next cycle, passthrough restored, no settle. Separately, pulse RESETn low mid-DRAIN -> outputs 0 asynchronously.

Source files
------------

// File: rtl/lc_isolation_sequencer.sv
// Sequenced isolation gate between a power-gated layer controller and the always-on domain.
// It drains in-flight request/ack handshakes, then clamps the outputs and holds them isolated for a settle window on release.
module lc_isolation_sequencer #(
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned REQ_W         = 4,
  parameter int unsigned HOLD_MODE     = 0,
  parameter int unsigned DRAIN_TIMEOUT = 255,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              ISO_REQ,
  input  logic [DATA_W-1:0] BUNDLE_IN,
  input  logic [REQ_W-1:0]  REQ_IN,
  input  logic [REQ_W-1:0]  ACK_IN,
  output logic [DATA_W-1:0] BUNDLE_OUT,
  output logic [REQ_W-1:0]  REQ_OUT,
  output logic              ISO_ACK,
  output logic              DRAIN_TO
);

  localparam int unsigned CNT_MAX = (DRAIN_TIMEOUT > SETTLE_CYCLES) ? DRAIN_TIMEOUT : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
  localparam logic             HOLD_EN     = (HOLD_MODE != 0);
  localparam logic             SETTLE_EN   = (SETTLE_CYCLES != 0);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_ISO    = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [REQ_W-1:0]   r_pending;
  logic [REQ_W-1:0]   w_pending_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [DATA_W-1:0]  r_snapshot;
  logic [DATA_W-1:0]  w_snapshot_nxt;
  logic               r_drain_to;
  logic               w_drain_to_nxt;

  logic [REQ_W-1:0]   w_pend_drain;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [DATA_W-1:0]  w_iso_bundle;

  // A pending line retires on its ack or when the requester withdraws it.
  assign w_pend_drain = r_pending & REQ_IN & ~ACK_IN;
  assign w_cnt_inc    = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_iso_bundle = HOLD_EN ? r_snapshot : '0;

  // State and datapath registers; reset lands in ISO with a zero snapshot.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state    <= S_ISO;
      r_pending  <= '0;
      r_cnt      <= '0;
      r_snapshot <= '0;
      r_drain_to <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_cnt      <= w_cnt_nxt;
      r_snapshot <= w_snapshot_nxt;
      r_drain_to <= w_drain_to_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_cnt_nxt      = r_cnt;
    w_snapshot_nxt = r_snapshot;
    w_drain_to_nxt = r_drain_to;
    case (r_state)
      S_RUN: begin
        if (ISO_REQ) begin
          w_state_nxt    = S_DRAIN;
          w_pending_nxt  = REQ_IN;
          w_cnt_nxt      = '0;
          w_drain_to_nxt = 1'b0;
        end
      end
      S_DRAIN: begin
        if (!ISO_REQ) begin
          w_state_nxt   = S_RUN;
          w_pending_nxt = '0;
          w_cnt_nxt     = '0;
        end else if (w_pend_drain == '0) begin
          // Clean drain takes priority over a coincident timeout.
          w_state_nxt   = S_ISO;
          w_pending_nxt = '0;
          w_cnt_nxt     = '0;
          if (HOLD_EN) begin
            w_snapshot_nxt = BUNDLE_IN;
          end
        end else if (r_cnt >= DRAIN_LAST) begin
          w_state_nxt    = S_ISO;
          w_pending_nxt  = '0;
          w_cnt_nxt      = '0;
          w_drain_to_nxt = 1'b1;
          if (HOLD_EN) begin
            w_snapshot_nxt = BUNDLE_IN;
          end
        end else begin
          w_pending_nxt = w_pend_drain;
          w_cnt_nxt     = w_cnt_inc;
        end
      end
      S_ISO: begin
        if (!ISO_REQ) begin
          w_state_nxt = SETTLE_EN ? S_SETTLE : S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      S_SETTLE: begin
        if (ISO_REQ) begin
          w_state_nxt = S_ISO;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= SETTLE_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_ISO;
      end
    endcase
  end

  // Output gating; passthrough is combinational so RUN adds no latency.
  always_comb begin
    BUNDLE_OUT = '0;
    REQ_OUT    = '0;
    ISO_ACK    = 1'b1;
    case (r_state)
      S_RUN: begin
        BUNDLE_OUT = BUNDLE_IN;
        REQ_OUT    = REQ_IN;
        ISO_ACK    = 1'b0;
      end
      S_DRAIN: begin
        BUNDLE_OUT = BUNDLE_IN;
        REQ_OUT    = REQ_IN & r_pending;
        ISO_ACK    = 1'b0;
      end
      default: begin
        BUNDLE_OUT = w_iso_bundle;
        REQ_OUT    = '0;
        ISO_ACK    = 1'b1;
      end
    endcase
  end

  assign DRAIN_TO = r_drain_to;

endmodule

// File: tb/tb_lc_isolation_sequencer.sv
// Bench for lc_isolation_sequencer: a clamp-mode and a hold-mode instance share all inputs.
// Vectors carry hand-derived expectations, queued on drive and compared on the falling edge.
module tb_lc_isolation_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;

  typedef struct {
    logic          iso;
    logic [DW-1:0] bin;
    logic [RW-1:0] rin;
    logic [RW-1:0] ain;
    logic [DW-1:0] eb0;
    logic [DW-1:0] eb1;
    logic [RW-1:0] erq;
    logic          eack;
    logic          edto;
    int            idx;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          iso_req;
  logic [DW-1:0] bin;
  logic [RW-1:0] rin;
  logic [RW-1:0] ain;
  logic [DW-1:0] b0, b1;
  logic [RW-1:0] r0, r1;
  logic          a0, a1, t0, t1;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  lc_isolation_sequencer #(
    .DATA_W(DW), .REQ_W(RW), .HOLD_MODE(0), .DRAIN_TIMEOUT(8), .SETTLE_CYCLES(4)
  ) dut0 (
    .CLK(clk), .RESETn(rst_n), .ISO_REQ(iso_req), .BUNDLE_IN(bin), .REQ_IN(rin), .ACK_IN(ain),
    .BUNDLE_OUT(b0), .REQ_OUT(r0), .ISO_ACK(a0), .DRAIN_TO(t0)
  );

  lc_isolation_sequencer #(
    .DATA_W(DW), .REQ_W(RW), .HOLD_MODE(1), .DRAIN_TIMEOUT(8), .SETTLE_CYCLES(4)
  ) dut1 (
    .CLK(clk), .RESETn(rst_n), .ISO_REQ(iso_req), .BUNDLE_IN(bin), .REQ_IN(rin), .ACK_IN(ain),
    .BUNDLE_OUT(b1), .REQ_OUT(r1), .ISO_ACK(a1), .DRAIN_TO(t1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic iso, input logic [DW-1:0] bi, input logic [RW-1:0] ri,
                              input logic [RW-1:0] ai, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic [RW-1:0] er, input logic ea, input logic ed);
    vec_t v;
    v.iso = iso; v.bin = bi; v.rin = ri; v.ain = ai;
    v.eb0 = e0; v.eb1 = e1; v.erq = er; v.eack = ea; v.edto = ed;
    v.idx = vecs.size();
    vecs.push_back(v);
  endfunction

  // Scoreboard side: compare the oldest queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      chk("bundle_clamp", e.idx, 32'(b0), 32'(e.eb0));
      chk("bundle_hold",  e.idx, 32'(b1), 32'(e.eb1));
      chk("req_out",      e.idx, 32'(r0), 32'(e.erq));
      chk("req_out_hold", e.idx, 32'(r1), 32'(e.erq));
      chk("iso_ack",      e.idx, 32'(a0), 32'(e.eack));
      chk("iso_ack_hold", e.idx, 32'(a1), 32'(e.eack));
      chk("drain_to",     e.idx, 32'(t0), 32'(e.edto));
    end
  end

  initial begin
    // Settle after reset: four SETTLE cycles, then passthrough.
    for (int k = 0; k < 4; k++) add(1'b0, 16'h00A5, 4'h0, 4'h0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
    add(1'b0, 16'h00A5, 4'h0, 4'h0, 16'h00A5, 16'h00A5, 4'h0, 1'b0, 1'b0);
    // Drain with late acks; REQ_IN[2] raised after entry must stay masked.
    add(1'b1, 16'h1234, 4'b0011, 4'b0000, 16'h1234, 16'h1234, 4'b0011, 1'b0, 1'b0);
    add(1'b1, 16'h1234, 4'b0111, 4'b0000, 16'h1234, 16'h1234, 4'b0011, 1'b0, 1'b0);
    add(1'b1, 16'h1234, 4'b0111, 4'b0001, 16'h1234, 16'h1234, 4'b0011, 1'b0, 1'b0);
    add(1'b1, 16'h1234, 4'b0111, 4'b0000, 16'h1234, 16'h1234, 4'b0010, 1'b0, 1'b0);
    add(1'b1, 16'h1234, 4'b0111, 4'b0000, 16'h1234, 16'h1234, 4'b0010, 1'b0, 1'b0);
    add(1'b1, 16'h1234, 4'b0111, 4'b0010, 16'h1234, 16'h1234, 4'b0010, 1'b0, 1'b0);
    // ISO with a changed bundle: clamp gives 0, hold keeps 0x1234.
    add(1'b1, 16'hFFFF, 4'b0111, 4'b0000, 16'h0, 16'h1234, 4'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 16'hFFFF, 4'b0111, 4'b0000, 16'h0, 16'h1234, 4'h0, 1'b1, 1'b0);
    // Re-raise in SETTLE cycle 2, then a full settle window again.
    add(1'b1, 16'hFFFF, 4'b0111, 4'b0000, 16'h0, 16'h1234, 4'h0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b0, 16'hFFFF, 4'b0111, 4'b0000, 16'h0, 16'h1234, 4'h0, 1'b1, 1'b0);
    add(1'b0, 16'hFFFF, 4'b0101, 4'b0000, 16'hFFFF, 16'hFFFF, 4'b0101, 1'b0, 1'b0);
    // Timeout: eight DRAIN cycles with no ack.
    for (int k = 0; k < 9; k++) add(1'b1, 16'h00C3, 4'b0001, 4'b0000, 16'h00C3, 16'h00C3, 4'b0001, 1'b0, 1'b0);
    add(1'b1, 16'h00C3, 4'b0001, 4'b0000, 16'h0, 16'h00C3, 4'h0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) add(1'b0, 16'h00C3, 4'b0001, 4'b0000, 16'h0, 16'h00C3, 4'h0, 1'b1, 1'b1);
    add(1'b0, 16'h00C3, 4'b0001, 4'b0000, 16'h00C3, 16'h00C3, 4'b0001, 1'b0, 1'b1);
    // Abort in DRAIN: sticky flag cleared on entry, straight back to RUN.
    add(1'b1, 16'h00C3, 4'b0001, 4'b0000, 16'h00C3, 16'h00C3, 4'b0001, 1'b0, 1'b1);
    add(1'b0, 16'h00C3, 4'b0001, 4'b0000, 16'h00C3, 16'h00C3, 4'b0001, 1'b0, 1'b0);
    add(1'b0, 16'h5A5A, 4'b0011, 4'b0000, 16'h5A5A, 16'h5A5A, 4'b0011, 1'b0, 1'b0);
    // Ack on the last allowed DRAIN cycle: clean drain, no timeout flag.
    for (int k = 0; k < 8; k++) add(1'b1, 16'h0077, 4'b0001, 4'b0000, 16'h0077, 16'h0077, 4'b0001, 1'b0, 1'b0);
    add(1'b1, 16'h0077, 4'b0001, 4'b0001, 16'h0077, 16'h0077, 4'b0001, 1'b0, 1'b0);
    add(1'b1, 16'h0077, 4'b0001, 4'b0000, 16'h0, 16'h0077, 4'h0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b0, 16'h0077, 4'b0001, 4'b0000, 16'h0, 16'h0077, 4'h0, 1'b1, 1'b0);
    // Re-enter DRAIN ahead of the asynchronous reset check.
    for (int k = 0; k < 2; k++) add(1'b1, 16'hBEEF, 4'b0001, 4'b0000, 16'hBEEF, 16'hBEEF, 4'b0001, 1'b0, 1'b0);

    rst_n   = 1'b0;
    iso_req = 1'b0;
    bin     = 16'h00A5;
    rin     = '0;
    ain     = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_bundle_clamp", -1, 32'(b0), 32'h0);
    chk("rst_bundle_hold",  -1, 32'(b1), 32'h0);
    chk("rst_req_out",      -1, 32'(r0), 32'h0);
    chk("rst_iso_ack",      -1, 32'(a0), 32'h1);
    chk("rst_drain_to",     -1, 32'(t1), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_iso_ack", -1, 32'(a1), 32'h1);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      iso_req = vecs[i].iso;
      bin     = vecs[i].bin;
      rin     = vecs[i].rin;
      ain     = vecs[i].ain;
      exp_q.push_back(vecs[i]);
    end

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    // Asynchronous reset in the middle of DRAIN.
    #2;
    chk("drain_pre_rst_ack", -2, 32'(a0), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_bundle_clamp", -2, 32'(b0), 32'h0);
    chk("async_rst_bundle_hold",  -2, 32'(b1), 32'h0);
    chk("async_rst_req_out",      -2, 32'(r1), 32'h0);
    chk("async_rst_iso_ack",      -2, 32'(a0), 32'h1);
    chk("async_rst_drain_to",     -2, 32'(t0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
